// File: rtl/ps_pcstk.sv
// PC stack register file for the program sequencer: CALL/RTS and ureg push/pop, combinational top-of-stack read.
// Optional sticky underflow flag ps_pcstk_unf is enabled by defining PCSTK_UNF_EN.
module ps_pcstk #(
  parameter int         DEPTH     = 30,
  parameter int         AW        = 16,
  parameter logic [4:0] PCSTK_ADD = 5'b00100
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ps_wrt_en,
  input  logic [4:0]    ps_wrt_add,
  input  logic [AW-1:0] ps_wrt_dat,
  input  logic [4:0]    ps_rd_add,
  input  logic          ps_popstck,
  input  logic          ps_call_push,
  input  logic [AW-1:0] ps_call_pc,
  input  logic          ps_rts_pop,
  input  logic          ps_stky_clr,
  output logic [AW-1:0] ps_pcstk_rd_dat,
  output logic [AW-1:0] ps_pcstk_top,
  output logic [4:0]    ps_pcstkp,
  output logic          ps_pcstk_empty,
  output logic          ps_pcstk_full,
  output logic          ps_pcstk_ovf
`ifdef PCSTK_UNF_EN
  ,
  output logic          ps_pcstk_unf
`endif
);

  logic [AW-1:0] stk_r [DEPTH];
  logic [4:0]    ptr_r;
  logic          ovf_r;

  logic          push_s;
  logic          pop_s;
  logic [AW-1:0] push_dat_s;
  logic          empty_s;
  logic          full_s;
  logic [4:0]    top_idx_s;
  logic          wr_en_s;
  logic [4:0]    wr_idx_s;
  logic [4:0]    ptr_nxt_s;
  logic          ovf_set_s;
  logic          unf_set_s;

  // Request decode; CALL data takes priority over a coincident ureg push.
  always_comb begin
    push_s     = ps_call_push | (ps_wrt_en & (ps_wrt_add == PCSTK_ADD));
    pop_s      = ps_popstck | ps_rts_pop;
    push_dat_s = ps_call_push ? ps_call_pc : ps_wrt_dat;
    empty_s    = (ptr_r == 5'd0);
    full_s     = (ptr_r == 5'(DEPTH));
    top_idx_s  = ptr_r - 5'd1;
  end

  // Next-state: write enable/index, pointer update and flag set conditions.
  always_comb begin
    wr_en_s   = 1'b0;
    wr_idx_s  = ptr_r;
    ptr_nxt_s = ptr_r;
    ovf_set_s = 1'b0;
    unf_set_s = 1'b0;
    case ({push_s, pop_s})
      2'b10: begin
        if (!full_s) begin
          wr_en_s   = 1'b1;
          ptr_nxt_s = ptr_r + 5'd1;
        end else begin
          ovf_set_s = 1'b1;
        end
      end
      2'b01: begin
        if (!empty_s) begin
          ptr_nxt_s = ptr_r - 5'd1;
        end else begin
          unf_set_s = 1'b1;
        end
      end
      2'b11: begin
        // Simultaneous push/pop replaces the top in place, even when full.
        wr_en_s = 1'b1;
        if (empty_s) begin
          ptr_nxt_s = ptr_r + 5'd1;
        end else begin
          wr_idx_s = top_idx_s;
        end
      end
      default: begin
        wr_en_s = 1'b0;
      end
    endcase
  end

  // Stack entry storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        stk_r[i] <= {AW{1'b0}};
      end
    end else if (wr_en_s) begin
      stk_r[wr_idx_s] <= push_dat_s;
    end
  end

  // Stack pointer and sticky overflow (set wins over clear).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_r <= 5'd0;
      ovf_r <= 1'b0;
    end else begin
      ptr_r <= ptr_nxt_s;
      if (ovf_set_s) begin
        ovf_r <= 1'b1;
      end else if (ps_stky_clr) begin
        ovf_r <= 1'b0;
      end
    end
  end

`ifdef PCSTK_UNF_EN
  logic unf_r;

  // Sticky underflow flag (set wins over clear).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      unf_r <= 1'b0;
    end else if (unf_set_s) begin
      unf_r <= 1'b1;
    end else if (ps_stky_clr) begin
      unf_r <= 1'b0;
    end
  end

  assign ps_pcstk_unf = unf_r;
`else
  logic unf_unused_s;
  assign unf_unused_s = unf_set_s;
`endif

  // Combinational read path; a read paired with a pop sees the pre-pop top.
  always_comb begin
    if (empty_s) begin
      ps_pcstk_top = {AW{1'b0}};
    end else begin
      ps_pcstk_top = stk_r[top_idx_s];
    end
    if (ps_rd_add == PCSTK_ADD) begin
      ps_pcstk_rd_dat = ps_pcstk_top;
    end else begin
      ps_pcstk_rd_dat = {AW{1'b0}};
    end
  end

  assign ps_pcstkp      = ptr_r;
  assign ps_pcstk_empty = empty_s;
  assign ps_pcstk_full  = full_s;
  assign ps_pcstk_ovf   = ovf_r;

endmodule

// File: tb/tb_ps_pcstk.sv
// Self-checking bench for ps_pcstk: directed scenarios plus randomized traffic against a queue-based model.
module tb_ps_pcstk;
  localparam int DEPTH = 30;
  localparam int AW    = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          ps_wrt_en;
  logic [4:0]    ps_wrt_add;
  logic [AW-1:0] ps_wrt_dat;
  logic [4:0]    ps_rd_add;
  logic          ps_popstck;
  logic          ps_call_push;
  logic [AW-1:0] ps_call_pc;
  logic          ps_rts_pop;
  logic          ps_stky_clr;
  logic [AW-1:0] ps_pcstk_rd_dat;
  logic [AW-1:0] ps_pcstk_top;
  logic [4:0]    ps_pcstkp;
  logic          ps_pcstk_empty;
  logic          ps_pcstk_full;
  logic          ps_pcstk_ovf;
`ifdef PCSTK_UNF_EN
  logic          ps_pcstk_unf;
`endif

  int total = 0;
  int bad   = 0;

  logic [AW-1:0] mq[$];
  logic          m_ovf;
  logic          m_unf;

  always #5 clk = ~clk;

  ps_pcstk #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .ps_wrt_en(ps_wrt_en), .ps_wrt_add(ps_wrt_add), .ps_wrt_dat(ps_wrt_dat),
    .ps_rd_add(ps_rd_add), .ps_popstck(ps_popstck),
    .ps_call_push(ps_call_push), .ps_call_pc(ps_call_pc),
    .ps_rts_pop(ps_rts_pop), .ps_stky_clr(ps_stky_clr),
    .ps_pcstk_rd_dat(ps_pcstk_rd_dat), .ps_pcstk_top(ps_pcstk_top),
    .ps_pcstkp(ps_pcstkp), .ps_pcstk_empty(ps_pcstk_empty),
    .ps_pcstk_full(ps_pcstk_full), .ps_pcstk_ovf(ps_pcstk_ovf)
`ifdef PCSTK_UNF_EN
    , .ps_pcstk_unf(ps_pcstk_unf)
`endif
  );

  function automatic logic [AW-1:0] m_top();
    if (mq.size() == 0) return 16'h0000;
    return mq[mq.size()-1];
  endfunction

  task automatic drive_idle();
    ps_wrt_en = 1'b0; ps_wrt_add = 5'd0; ps_wrt_dat = 16'h0000;
    ps_rd_add = 5'd0; ps_popstck = 1'b0; ps_call_push = 1'b0;
    ps_call_pc = 16'h0000; ps_rts_pop = 1'b0; ps_stky_clr = 1'b0;
  endtask

  // Applies the currently driven inputs to the model, then clocks the DUT.
  task automatic clock_step();
    logic push, pop, ovf_set, unf_set;
    logic [AW-1:0] d;
    push = ps_call_push | (ps_wrt_en & (ps_wrt_add == 5'b00100));
    pop  = ps_popstck | ps_rts_pop;
    d    = ps_call_push ? ps_call_pc : ps_wrt_dat;
    ovf_set = 1'b0;
    unf_set = 1'b0;
    if (push && pop) begin
      if (mq.size() == 0) mq.push_back(d);
      else mq[mq.size()-1] = d;
    end else if (push) begin
      if (mq.size() < DEPTH) mq.push_back(d);
      else ovf_set = 1'b1;
    end else if (pop) begin
      if (mq.size() > 0) void'(mq.pop_back());
      else unf_set = 1'b1;
    end
    m_ovf = ovf_set ? 1'b1 : (ps_stky_clr ? 1'b0 : m_ovf);
    m_unf = unf_set ? 1'b1 : (ps_stky_clr ? 1'b0 : m_unf);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive_idle();
    rst_n = 1'b0;
    mq.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    drive_idle();
    rst_n = 1'b0;
    ps_rd_add = 5'b00100;
    #2;
    total += 6;
    if (ps_pcstkp !== 5'd0) begin bad++; $display("FAIL reset_ptr got=%0d exp=0", ps_pcstkp); end
    if (ps_pcstk_empty !== 1'b1) begin bad++; $display("FAIL reset_empty got=%b exp=1", ps_pcstk_empty); end
    if (ps_pcstk_full !== 1'b0) begin bad++; $display("FAIL reset_full got=%b exp=0", ps_pcstk_full); end
    if (ps_pcstk_top !== 16'h0000) begin bad++; $display("FAIL reset_top got=%h exp=0000", ps_pcstk_top); end
    if (ps_pcstk_rd_dat !== 16'h0000) begin bad++; $display("FAIL reset_rd got=%h exp=0000", ps_pcstk_rd_dat); end
    if (ps_pcstk_ovf !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b exp=0", ps_pcstk_ovf); end
    do_reset();
  endtask

  task automatic test_ureg_push();
    do_reset();
    ps_wrt_en = 1'b1; ps_wrt_add = 5'b00100; ps_wrt_dat = 16'h1234;
    clock_step();
    drive_idle();
    ps_rd_add = 5'b00100;
    #1;
    total += 4;
    if (ps_pcstkp !== 5'd1) begin bad++; $display("FAIL ureg_ptr got=%0d exp=1", ps_pcstkp); end
    if (ps_pcstk_top !== 16'h1234) begin bad++; $display("FAIL ureg_top got=%h exp=1234", ps_pcstk_top); end
    if (ps_pcstk_empty !== 1'b0) begin bad++; $display("FAIL ureg_empty got=%b exp=0", ps_pcstk_empty); end
    if (ps_pcstk_rd_dat !== 16'h1234) begin bad++; $display("FAIL ureg_rd got=%h exp=1234", ps_pcstk_rd_dat); end
    ps_rd_add = 5'b00101;
    #1;
    total++;
    if (ps_pcstk_rd_dat !== 16'h0000) begin bad++; $display("FAIL ureg_rd_other got=%h exp=0000", ps_pcstk_rd_dat); end
    // Write to a different ureg address must not push.
    ps_wrt_en = 1'b1; ps_wrt_add = 5'b00101; ps_wrt_dat = 16'h5555;
    clock_step();
    drive_idle();
    total++;
    if (ps_pcstkp !== 5'd1) begin bad++; $display("FAIL ureg_wrong_add_ptr got=%0d exp=1", ps_pcstkp); end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      ps_call_push = 1'b1; ps_call_pc = 16'(i + 1);
      clock_step();
    end
    drive_idle();
    total += 3;
    if (ps_pcstk_full !== 1'b1) begin bad++; $display("FAIL ovf_full got=%b exp=1", ps_pcstk_full); end
    if (ps_pcstkp !== 5'd30) begin bad++; $display("FAIL ovf_ptr got=%0d exp=30", ps_pcstkp); end
    if (ps_pcstk_top !== 16'd30) begin bad++; $display("FAIL ovf_top got=%0d exp=30", ps_pcstk_top); end
    ps_call_push = 1'b1; ps_call_pc = 16'd31;
    clock_step();
    drive_idle();
    total += 3;
    if (ps_pcstk_ovf !== 1'b1) begin bad++; $display("FAIL ovf_set got=%b exp=1", ps_pcstk_ovf); end
    if (ps_pcstk_top !== 16'd30) begin bad++; $display("FAIL ovf_top_kept got=%0d exp=30", ps_pcstk_top); end
    if (ps_pcstkp !== 5'd30) begin bad++; $display("FAIL ovf_ptr_kept got=%0d exp=30", ps_pcstkp); end
    // Overflow and clear in the same cycle: set wins.
    ps_call_push = 1'b1; ps_call_pc = 16'd32; ps_stky_clr = 1'b1;
    clock_step();
    drive_idle();
    total++;
    if (ps_pcstk_ovf !== 1'b1) begin bad++; $display("FAIL ovf_set_wins got=%b exp=1", ps_pcstk_ovf); end
    ps_stky_clr = 1'b1;
    clock_step();
    drive_idle();
    total++;
    if (ps_pcstk_ovf !== 1'b0) begin bad++; $display("FAIL ovf_clr got=%b exp=0", ps_pcstk_ovf); end
  endtask

  task automatic test_pop_empty();
    do_reset();
    ps_call_push = 1'b1; ps_call_pc = 16'hAAAA;
    clock_step();
    drive_idle();
    ps_rts_pop = 1'b1;
    clock_step();
    drive_idle();
    total += 3;
    if (ps_pcstkp !== 5'd0) begin bad++; $display("FAIL pop_ptr got=%0d exp=0", ps_pcstkp); end
    if (ps_pcstk_empty !== 1'b1) begin bad++; $display("FAIL pop_empty got=%b exp=1", ps_pcstk_empty); end
    if (ps_pcstk_top !== 16'h0000) begin bad++; $display("FAIL pop_top got=%h exp=0000", ps_pcstk_top); end
    ps_popstck = 1'b1;
    clock_step();
    drive_idle();
    total++;
    if (ps_pcstkp !== 5'd0) begin bad++; $display("FAIL pop_empty_ptr got=%0d exp=0", ps_pcstkp); end
`ifdef PCSTK_UNF_EN
    total++;
    if (ps_pcstk_unf !== 1'b1) begin bad++; $display("FAIL unf_set got=%b exp=1", ps_pcstk_unf); end
`endif
  endtask

  task automatic test_replace();
    do_reset();
    ps_call_push = 1'b1; ps_call_pc = 16'h0011;
    clock_step();
    ps_call_pc = 16'h0022;
    clock_step();
    drive_idle();
    // Read paired with pop returns the pre-pop top.
    ps_rd_add = 5'b00100; ps_popstck = 1'b1;
    #1;
    total++;
    if (ps_pcstk_rd_dat !== 16'h0022) begin bad++; $display("FAIL read_before_pop got=%h exp=0022", ps_pcstk_rd_dat); end
    drive_idle();
    ps_call_push = 1'b1; ps_call_pc = 16'h0033; ps_rts_pop = 1'b1;
    clock_step();
    drive_idle();
    total += 2;
    if (ps_pcstkp !== 5'd2) begin bad++; $display("FAIL replace_ptr got=%0d exp=2", ps_pcstkp); end
    if (ps_pcstk_top !== 16'h0033) begin bad++; $display("FAIL replace_top got=%h exp=0033", ps_pcstk_top); end
    ps_popstck = 1'b1;
    clock_step();
    drive_idle();
    total++;
    if (ps_pcstk_top !== 16'h0011) begin bad++; $display("FAIL replace_below got=%h exp=0011", ps_pcstk_top); end
  endtask

  task automatic test_call_wins();
    do_reset();
    ps_call_push = 1'b1; ps_call_pc = 16'h0100;
    ps_wrt_en = 1'b1; ps_wrt_add = 5'b00100; ps_wrt_dat = 16'h0200;
    clock_step();
    drive_idle();
    total += 2;
    if (ps_pcstkp !== 5'd1) begin bad++; $display("FAIL call_wins_ptr got=%0d exp=1", ps_pcstkp); end
    if (ps_pcstk_top !== 16'h0100) begin bad++; $display("FAIL call_wins_top got=%h exp=0100", ps_pcstk_top); end
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      ps_call_push = 1'b1; ps_call_pc = 16'(16'h0a00 + i);
      clock_step();
    end
    drive_idle();
    total++;
    if (ps_pcstkp !== 5'd5) begin bad++; $display("FAIL async_pre_ptr got=%0d exp=5", ps_pcstkp); end
    #2;
    rst_n = 1'b0;
    #1;
    total += 4;
    if (ps_pcstkp !== 5'd0) begin bad++; $display("FAIL async_ptr got=%0d exp=0", ps_pcstkp); end
    if (ps_pcstk_ovf !== 1'b0) begin bad++; $display("FAIL async_ovf got=%b exp=0", ps_pcstk_ovf); end
    if (ps_pcstk_top !== 16'h0000) begin bad++; $display("FAIL async_top got=%h exp=0000", ps_pcstk_top); end
    if (ps_pcstk_empty !== 1'b1) begin bad++; $display("FAIL async_empty got=%b exp=1", ps_pcstk_empty); end
    do_reset();
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 600; n++) begin
      int push_pct;
      push_pct = ((n / 100) % 2 == 0) ? 75 : 30;
      drive_idle();
      ps_call_push = ($urandom_range(99) < push_pct / 2);
      ps_call_pc   = 16'($urandom);
      ps_wrt_en    = ($urandom_range(99) < push_pct / 2);
      ps_wrt_add   = ($urandom_range(3) == 0) ? 5'($urandom) : 5'b00100;
      ps_wrt_dat   = 16'($urandom);
      ps_popstck   = ($urandom_range(99) < 20);
      ps_rts_pop   = ($urandom_range(99) < 20);
      ps_stky_clr  = ($urandom_range(99) < 8);
      ps_rd_add    = ($urandom_range(1) == 0) ? 5'b00100 : 5'($urandom);
      clock_step();
      total += 6;
      if (ps_pcstkp !== 5'(mq.size())) begin bad++; $display("FAIL rnd_ptr cyc=%0d got=%0d exp=%0d", n, ps_pcstkp, mq.size()); end
      if (ps_pcstk_top !== m_top()) begin bad++; $display("FAIL rnd_top cyc=%0d got=%h exp=%h", n, ps_pcstk_top, m_top()); end
      if (ps_pcstk_empty !== (mq.size() == 0)) begin bad++; $display("FAIL rnd_empty cyc=%0d got=%b", n, ps_pcstk_empty); end
      if (ps_pcstk_full !== (mq.size() == DEPTH)) begin bad++; $display("FAIL rnd_full cyc=%0d got=%b", n, ps_pcstk_full); end
      if (ps_pcstk_ovf !== m_ovf) begin bad++; $display("FAIL rnd_ovf cyc=%0d got=%b exp=%b", n, ps_pcstk_ovf, m_ovf); end
      if (ps_pcstk_rd_dat !== ((ps_rd_add == 5'b00100) ? m_top() : 16'h0000)) begin
        bad++; $display("FAIL rnd_rd cyc=%0d got=%h add=%0d top=%h", n, ps_pcstk_rd_dat, ps_rd_add, m_top());
      end
`ifdef PCSTK_UNF_EN
      total++;
      if (ps_pcstk_unf !== m_unf) begin bad++; $display("FAIL rnd_unf cyc=%0d got=%b exp=%b", n, ps_pcstk_unf, m_unf); end
`endif
    end
    drive_idle();
  endtask

  initial begin
    drive_idle();
    rst_n = 1'b0;
    m_ovf = 1'b0;
    m_unf = 1'b0;
    test_reset();
    test_ureg_push();
    test_overflow();
    test_pop_empty();
    test_replace();
    test_call_wins();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
